// File: rtl/race_supervisor.sv
// Maze game-flow controller: start/restart/finish sequencing, stopwatch control,
// best-time record, and the four-digit display select feeding scan_ctl.
module race_supervisor #(
    parameter logic [4:0] GOAL_ROW = 5'd22,
    parameter logic [4:0] GOAL_COL = 5'd30,
    parameter logic [3:0] BLANK    = 4'd10
) (
    input  logic       clk_10Hz,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_view,
    input  logic [4:0] row,
    input  logic [4:0] column,
    input  logic [3:0] sec0,
    input  logic [3:0] sec1,
    input  logic [3:0] min0,
    input  logic [3:0] min1,
    output logic       run_en,
    output logic       clr_watch,
    output logic       finished,
    output logic       new_record,
    output logic [3:0] in0,
    output logic [3:0] in1,
    output logic [3:0] in2,
    output logic [3:0] in3
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nx;
    logic        start_q, view_q, start_edge, view_edge, goal;
    logic        view, best_valid;
    logic        clr_nx, latch, rec_clr;
    logic [15:0] best_time, last_time, live_time, disp;

    assign start_edge = btn_start & ~start_q;
    assign view_edge  = btn_view & ~view_q;
    assign goal       = (row == GOAL_ROW) && (column == GOAL_COL);
    assign live_time  = {min1, min0, sec1, sec0};

    // Goal has priority over a simultaneous restart request in RUN.
    always_comb begin
        state_nx = state;
        clr_nx   = 1'b0;
        latch    = 1'b0;
        rec_clr  = 1'b0;
        case (state)
            IDLE: if (start_edge) begin
                state_nx = RUN;
                clr_nx   = 1'b1;
            end
            RUN: begin
                if (goal) begin
                    state_nx = DONE;
                    latch    = 1'b1;
                end else if (start_edge) begin
                    clr_nx = 1'b1;
                end
            end
            DONE: if (start_edge) begin
                state_nx = IDLE;
                rec_clr  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_10Hz or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            view_q    <= 1'b0;
            view      <= 1'b0;
            run_en    <= 1'b0;
            clr_watch <= 1'b0;
            finished  <= 1'b0;
        end else begin
            state     <= state_nx;
            start_q   <= btn_start;
            view_q    <= btn_view;
            run_en    <= (state_nx == RUN);
            finished  <= (state_nx == DONE);
            clr_watch <= clr_nx;
            if (view_edge)
                view <= ~view;
        end
    end

    // Packed BCD compares correctly as an unsigned binary value.
    always_ff @(posedge clk_10Hz or posedge rst) begin
        if (rst) begin
            last_time  <= 16'h0;
            best_time  <= 16'h0;
            best_valid <= 1'b0;
            new_record <= 1'b0;
        end else if (latch) begin
            last_time <= live_time;
            if (!best_valid || live_time < best_time) begin
                best_time  <= live_time;
                best_valid <= 1'b1;
                new_record <= 1'b1;
            end else begin
                new_record <= 1'b0;
            end
        end else if (rec_clr) begin
            new_record <= 1'b0;
        end
    end

    always_comb begin
        disp = live_time;
        if (view)
            disp = best_valid ? best_time : {4{BLANK}};
        else if (state == DONE)
            disp = last_time;
    end

    assign in0 = disp[3:0];
    assign in1 = disp[7:4];
    assign in2 = disp[11:8];
    assign in3 = disp[15:12];
endmodule

// File: tb/tb_race_supervisor.sv
// Directed + randomized checks of race_supervisor against a per-cycle game model.
module tb_race_supervisor;
    logic       clk_10Hz = 1'b0;
    logic       rst, btn_start, btn_view;
    logic [4:0] row, column;
    logic [3:0] sec0, sec1, min0, min1;
    logic       run_en, clr_watch, finished, new_record;
    logic [3:0] in0, in1, in2, in3;

    race_supervisor dut (
        .clk_10Hz(clk_10Hz), .rst(rst), .btn_start(btn_start), .btn_view(btn_view),
        .row(row), .column(column), .sec0(sec0), .sec1(sec1), .min0(min0), .min1(min1),
        .run_en(run_en), .clr_watch(clr_watch), .finished(finished), .new_record(new_record),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3)
    );

    always #50 clk_10Hz = ~clk_10Hz;

    int n_cmp = 0, n_err = 0;

    // Model: mode 0 = waiting, 1 = racing, 2 = finished.
    int          m_mode;
    bit          m_rec, m_clr, m_view, m_bv, m_sq, m_vq;
    logic [15:0] m_best, m_last;

    function automatic logic [15:0] disp();
        return {in3, in2, in1, in0};
    endfunction

    function automatic logic [15:0] live();
        return {min1, min0, sec1, sec0};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_rec = 0; m_clr = 0; m_view = 0; m_bv = 0;
        m_sq = 0; m_vq = 0; m_best = 16'h0; m_last = 16'h0;
    endtask

    task automatic model_tick();
        bit se, ve, at_goal;
        logic [15:0] t;
        se = btn_start && !m_sq;
        ve = btn_view && !m_vq;
        at_goal = (row == 5'd22) && (column == 5'd30);
        t = live();
        m_clr = 0;
        if (m_mode == 0) begin
            if (se) begin m_mode = 1; m_clr = 1; end
        end else if (m_mode == 1) begin
            if (at_goal) begin
                m_mode = 2;
                m_last = t;
                m_rec = (!m_bv) || (t < m_best);
                if (m_rec) begin m_best = t; m_bv = 1; end
            end else if (se) m_clr = 1;
        end else if (se) begin
            m_mode = 0; m_rec = 0;
        end
        if (ve) m_view = !m_view;
        m_sq = btn_start; m_vq = btn_view;
    endtask

    task automatic check_all();
        logic [15:0] e;
        if (m_view) e = m_bv ? m_best : 16'hAAAA;
        else if (m_mode == 2) e = m_last;
        else e = live();
        chk("run_en", 16'(run_en), 16'(m_mode == 1));
        chk("clr_watch", 16'(clr_watch), 16'(m_clr));
        chk("finished", 16'(finished), 16'(m_mode == 2));
        chk("new_record", 16'(new_record), 16'(m_rec));
        chk("display", disp(), e);
    endtask

    task automatic step();
        @(posedge clk_10Hz);
        model_tick();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk_10Hz);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_t(input logic [15:0] t, input bit g);
        {min1, min0, sec1, sec0} = t;
        row    = g ? 5'd22 : 5'd3;
        column = g ? 5'd30 : 5'd7;
    endtask

    task automatic press_start();
        btn_start = 1; step();
        btn_start = 0; step();
    endtask

    initial begin
        rst = 1'b1; btn_start = 0; btn_view = 0;
        set_t(16'h0000, 0);
        do_reset();
        chk("rst_run_en", 16'(run_en), 16'h0);
        set_t(16'h4321, 0); #1;
        chk("idle_live", disp(), 16'h4321);

        // start: clr_watch exactly one cycle
        btn_start = 1; step();
        chk("start_run_en", 16'(run_en), 16'h1);
        chk("start_clr", 16'(clr_watch), 16'h1);
        btn_start = 0; step();
        chk("start_clr_off", 16'(clr_watch), 16'h0);
        chk("start_not_fin", 16'(finished), 16'h0);

        // first finish sets the record
        set_t(16'h0125, 1); step();
        chk("fin1_finished", 16'(finished), 16'h1);
        chk("fin1_record", 16'(new_record), 16'h1);
        set_t(16'h0199, 1); step();
        chk("fin1_hold", disp(), 16'h0125);
        set_t(16'h0200, 0);

        // slower run, then a tie: neither is a record
        press_start(); press_start();
        set_t(16'h0130, 1); step();
        chk("fin2_record", 16'(new_record), 16'h0);
        chk("fin2_last", disp(), 16'h0130);
        btn_view = 1; step();
        chk("fin2_best", disp(), 16'h0125);
        btn_view = 0; step(); btn_view = 1; step(); btn_view = 0; step();
        set_t(16'h0000, 0);
        press_start(); press_start();
        set_t(16'h0125, 1); step();
        chk("tie_record", 16'(new_record), 16'h0);
        chk("tie_finished", 16'(finished), 16'h1);

        // view with no record shows blanks
        do_reset();
        set_t(16'h0312, 0);
        btn_view = 1; step();
        chk("blank_view", disp(), 16'hAAAA);
        btn_view = 0; step(); btn_view = 1; step();
        chk("live_view", disp(), 16'h0312);
        btn_view = 0; step();

        // restart and goal in the same cycle: goal wins
        press_start();
        btn_start = 1; set_t(16'h0042, 1); step();
        chk("same_finished", 16'(finished), 16'h1);
        chk("same_clr", 16'(clr_watch), 16'h0);
        btn_start = 0; set_t(16'h0050, 0); step();

        // async reset in DONE with a record
        #20 rst = 1'b1; #1;
        model_reset();
        chk("arst_finished", 16'(finished), 16'h0);
        chk("arst_record", 16'(new_record), 16'h0);
        @(posedge clk_10Hz); #1; rst = 1'b0;
        btn_view = 1; step();
        chk("arst_blank", disp(), 16'hAAAA);
        btn_view = 0; step();

        // randomized play
        for (int i = 0; i < 600; i++) begin
            bit g;
            if ($urandom % 97 == 0) do_reset();
            g = ($urandom % 6 == 0);
            btn_start = ($urandom % 4 == 0);
            btn_view  = ($urandom % 9 == 0);
            sec0 = 4'($urandom % 10); sec1 = 4'($urandom % 6);
            min0 = 4'($urandom % 10); min1 = 4'($urandom % 6);
            row    = g ? 5'd22 : 5'($urandom % 32);
            column = g ? 5'd30 : 5'($urandom % 32);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/race_supervisor.md
# race_supervisor

Game-flow controller for the maze design, clocked at 10 Hz. It consumes the stopwatch BCD digits and the character cell position, and produces three things: the stopwatch run/clear controls, the finish detection, and the four digits sent to the seven-segment scan controller. It sits between the stopwatch/maps pair upstream and `scan_ctl` downstream, replacing the ad-hoc display-select logic at top level. It also keeps a best-time record across attempts.

## Interface
Parameters:
- GOAL_ROW, 5'd22, row index of the goal cell
- GOAL_COL, 5'd30, column index of the goal cell
- BLANK, 4'd10, digit code that `display` renders as blank

Ports:
- clk_10Hz  in  1  system clock for this block (10 Hz tick from clock_divisor)
- rst  in  1  reset, asynchronous, active-high
- btn_start  in  1  start/restart button level (debounced by sampling at 10 Hz)
- btn_view  in  1  display-view toggle button level
- row  in  5  current character row (from maps)
- column  in  5  current character column (from maps)
- sec0, sec1, min0, min1  in  4 each  live stopwatch BCD digits
- run_en  out  1  stopwatch count enable
- clr_watch  out  1  stopwatch clear pulse
- finished  out  1  high while in DONE
- new_record  out  1  high in DONE when the last run set a new best time
- in0, in1, in2, in3  out  4 each  digits to scan_ctl (in0 = rightmost)

## Operation
- Edge detect: `start_q` and `view_q` are previous-sample registers, reset to 0.
  - start_edge = btn_start & ~start_q; view_edge likewise.
  - A button held through reset release produces one edge on the first clock.
- FSM states are IDLE, RUN, DONE. Reset state is IDLE.
  - IDLE: start_edge → RUN.
  - RUN, goal reached (row==GOAL_ROW && column==GOAL_COL):
    - go to DONE;
    - latch {min1,min0,sec1,sec0} into last_time (16 bits);
    - if best_valid==0 or last_time < best_time (unsigned 16-bit compare of packed BCD), load best_time, set best_valid=1, and set new_record=1.
  - RUN, start_edge with goal not reached: restart. Stay in RUN and pulse clr_watch.
  - RUN, both start_edge and goal reached: goal wins and start_edge is ignored.
  - DONE: start_edge → IDLE and clears new_record. last_time and the best record are retained.
- Entering RUN from IDLE or restarting in RUN: clr_watch=1 for exactly the next cycle.
- run_en = (state==RUN), registered.
- The view register toggles on view_edge in any state.
- Display mux (combinational):
  - view=0, state DONE: last_time digits.
  - view=0, otherwise: live sec0..min1 passed through.
  - view=1, best_valid=1: best_time digits.
  - view=1, best_valid=0: all four digits = BLANK.
- Digit order: in0=sec0, in1=sec1, in2=min0, in3=min1.

## Timing
- Reset values:
  - state IDLE; run_en, clr_watch, finished, new_record all 0;
  - view 0; best_valid 0; best_time 16'h0; last_time 16'h0;
  - in0..in3 follow the live digits (IDLE, view 0).
- start_edge sampled at edge n (IDLE): state=RUN, run_en=1, clr_watch=1 at n+1; clr_watch=0 at n+2.
- Goal sampled at edge n (RUN): finished=1, run_en=0, last_time/new_record valid at n+1.
  - The stopwatch may advance by up to one 10 Hz period after the latch. last_time is authoritative.
- A tie with best_time is not a new record (strict less-than).
- Asynchronous rst mid-RUN: outputs return to reset values immediately. The best record is lost.
- Button edges are one cycle wide. A held button generates no further edges.

## Test plan
- Reset, then btn_start high for 1 cycle → n+1: run_en=1, clr_watch=1; n+2: clr_watch=0, finished=0.
- RUN, drive digits 0:1:2:5 (min1..sec0 = 0,1,2,5) with row=22, column=30 → finished=1, run_en=0, new_record=1, in3..in0 = 0,1,2,5 held while the digits change.
- btn_start → IDLE. Second run finishes at 0,1,3,0 → new_record=0, best stays 0125. A third run at exactly 0,1,2,5 → new_record=0.
- btn_view edge with no record after reset → in0..in3 = 10,10,10,10. A second edge → live digits.
- RUN with btn_start edge and goal cell in the same cycle → DONE, and clr_watch stays 0.
- Assert rst while in DONE with best_valid=1 → state IDLE, finished=0. view=1 then shows blanks.
